// File: rtl/pokey_audio_gen_if.sv
// Register bus between a host CPU and pokey_audio_gen.
// The strobe is held until ack_o is seen; dat_o is valid while ack_o is high.
interface pokey_audio_gen_if #(
  parameter int unsigned AW = 4
) ();
  logic [AW-1:0] adr_i;
  logic [7:0]    dat_i;
  logic          we_i;
  logic          stb_i;
  logic          ack_o;
  logic [7:0]    dat_o;

  modport master (
    output adr_i, dat_i, we_i, stb_i,
    input  ack_o, dat_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, stb_i,
    output ack_o, dat_o
  );
endinterface

// File: rtl/pokey_audio_gen.sv
// pokey_audio_gen: NCH-channel POKEY-style sound generator.
// Each channel is an 8-bit divide-by-(AUDF+1) counter. Its flip-flop is toggled or
// loaded from shared poly4/poly5/poly17 noise. Channel pairs can be linked into
// cascaded dividers. The channel volumes are summed into a registered mix output.
// Define POKEY_GEN_FILTER_EN to build the optional per-channel high-pass filters.
module pokey_audio_gen #(
  parameter int unsigned NCH       = 4,
  parameter int unsigned PRE_DIV   = 28,
  parameter int unsigned PRE_MUL15 = 4,
  localparam int unsigned AW       = $clog2(2 * NCH + 5),
  localparam int unsigned OW       = 4 + $clog2(NCH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  pokey_audio_gen_if.slave bus,
  output logic [OW-1:0]    audout,
  output logic [NCH-1:0]   chan_pulse
);

  localparam int unsigned NP = NCH / 2;
  localparam int unsigned PW = $clog2(PRE_DIV + 1);
  localparam int unsigned MW = $clog2(PRE_MUL15 + 1);

  localparam logic [31:0] AdrCtl    = 32'(2 * NCH);
  localparam logic [31:0] AdrLink   = 32'(2 * NCH + 1);
  localparam logic [31:0] AdrFilt   = 32'(2 * NCH + 2);
  localparam logic [31:0] AdrStimer = 32'(2 * NCH + 3);
  localparam logic [31:0] AdrRandom = 32'(2 * NCH + 4);

  logic [31:0]    adr_w;
  logic           acc, wr, stimer_wr;
  logic           ack_q;
  logic [7:0]     dat_q, rdat;

  logic [7:0]     audf_q [NCH];
  logic [7:0]     audf_d [NCH];
  logic [7:0]     audc_q [NCH];
  logic [7:0]     audc_d [NCH];
  logic [2:0]     ctl_q, ctl_d;
  logic [NP-1:0]  link_q, link_d;

  logic [PW-1:0]  pre_q, pre_d;
  logic [MW-1:0]  m15_q, m15_d;
  logic           base_tick, tick;

  logic [7:0]     cnt_q [NCH];
  logic [7:0]     cnt_d [NCH];
  logic [NCH-1:0] ff_q, ff_d, ff_out, tick_ch, pulse;

  logic [3:0]     poly4_q, poly4_d;
  logic [4:0]     poly5_q, poly5_d;
  logic [16:0]    poly17_q, poly17_d;
  logic           fb17;
  logic [7:0]     rnd;

  logic [OW-1:0]  audout_q, audout_d;

`ifdef POKEY_GEN_FILTER_EN
  logic [NP-1:0]  filt_q, filt_d, hp_q, hp_d;
`endif

  assign adr_w     = 32'(bus.adr_i);
  // Only a fresh strobe is accepted; the ack cycle blocks a held strobe.
  assign acc       = bus.stb_i && !ack_q;
  assign wr        = acc && bus.we_i;
  assign stimer_wr = wr && (adr_w == AdrStimer);

  // Read mux, sampled into dat_q at acceptance.
  always_comb begin
    rdat = 8'hFF;
    for (int i = 0; i < NCH; i++) begin
      if (adr_w == 32'(2 * i))     rdat = audf_q[i];
      if (adr_w == 32'(2 * i + 1)) rdat = audc_q[i];
    end
    if (adr_w == AdrCtl)    rdat = {5'b0, ctl_q};
    if (adr_w == AdrLink)   rdat = 8'(link_q);
`ifdef POKEY_GEN_FILTER_EN
    if (adr_w == AdrFilt)   rdat = 8'(filt_q);
`else
    if (adr_w == AdrFilt)   rdat = 8'h00;
`endif
    if (adr_w == AdrStimer) rdat = 8'h00;
    if (adr_w == AdrRandom) rdat = rnd;
  end

  // Register-file writes.
  always_comb begin
    audf_d = audf_q;
    audc_d = audc_q;
    ctl_d  = ctl_q;
    link_d = link_q;
`ifdef POKEY_GEN_FILTER_EN
    filt_d = filt_q;
`endif
    if (wr) begin
      for (int i = 0; i < NCH; i++) begin
        if (adr_w == 32'(2 * i))     audf_d[i] = bus.dat_i;
        if (adr_w == 32'(2 * i + 1)) audc_d[i] = bus.dat_i;
      end
      if (adr_w == AdrCtl)  ctl_d  = bus.dat_i[2:0];
      if (adr_w == AdrLink) link_d = bus.dat_i[NP-1:0];
`ifdef POKEY_GEN_FILTER_EN
      if (adr_w == AdrFilt) filt_d = bus.dat_i[NP-1:0];
`endif
    end
  end

  // Prescaler: base tick every PRE_DIV clocks, 15 kHz tick every PRE_MUL15 base ticks.
  always_comb begin
    base_tick = (pre_q == PW'(PRE_DIV - 1));
    tick      = ctl_q[0] ? (base_tick && (m15_q == MW'(PRE_MUL15 - 1))) : base_tick;
    pre_d     = base_tick ? '0 : pre_q + PW'(1);
    m15_d     = m15_q;
    if (base_tick) m15_d = (m15_q == MW'(PRE_MUL15 - 1)) ? '0 : m15_q + MW'(1);
    if (stimer_wr) begin
      pre_d = '0;
      m15_d = '0;
    end
  end

  // Channel clocking: even channels first so linked odd channels can see their pulse.
  always_comb begin
    tick_ch = '0;
    pulse   = '0;
    for (int k = 0; k < NP; k++) begin
      tick_ch[2*k] = ctl_q[2] | tick;
      pulse[2*k]   = tick_ch[2*k] && (cnt_q[2*k] == 8'd0) && !stimer_wr;
    end
    for (int k = 0; k < NP; k++) begin
      tick_ch[2*k+1] = link_q[k] ? pulse[2*k] : tick;
      pulse[2*k+1]   = tick_ch[2*k+1] && (cnt_q[2*k+1] == 8'd0) && !stimer_wr;
    end
  end

  // Counter reload/decrement and flip-flop update per channel.
  always_comb begin
    cnt_d = cnt_q;
    ff_d  = ff_q;
    for (int i = 0; i < NCH; i++) begin
      if (stimer_wr) begin
        cnt_d[i] = audf_q[i];
        ff_d[i]  = 1'b0;
      end else if (tick_ch[i]) begin
        cnt_d[i] = (cnt_q[i] == 8'd0) ? audf_q[i] : cnt_q[i] - 8'd1;
      end
      if (pulse[i] && (audc_q[i][7] | poly5_q[0])) begin
        if (audc_q[i][5])      ff_d[i] = ~ff_q[i];
        else if (audc_q[i][6]) ff_d[i] = poly4_q[0];
        else                   ff_d[i] = poly17_q[0];
      end
    end
  end

  // Noise LFSRs (XNOR, so the all-zero reset state is legal); poly9 reuses the low bits.
  always_comb begin
    poly4_d  = {poly4_q[2:0], ~(poly4_q[3] ^ poly4_q[2])};
    poly5_d  = {poly5_q[3:0], ~(poly5_q[4] ^ poly5_q[2])};
    fb17     = ctl_q[1] ? ~(poly17_q[8] ^ poly17_q[4]) : ~(poly17_q[16] ^ poly17_q[11]);
    poly17_d = {poly17_q[15:0], fb17};
    rnd      = ctl_q[1] ? poly17_q[8:1] : poly17_q[16:9];
  end

`ifdef POKEY_GEN_FILTER_EN
  // High-pass: latch the channel's new ff on the partner pulse so equal rates cancel.
  always_comb begin
    hp_d = hp_q;
    for (int k = 0; k < NP; k++) begin
      if (stimer_wr || !filt_q[k]) hp_d[k] = 1'b0;
      else if (pulse[k+NP])        hp_d[k] = ff_d[k];
    end
  end
`endif

  // Effective per-channel ff after optional filtering.
  always_comb begin
    ff_out = ff_q;
`ifdef POKEY_GEN_FILTER_EN
    for (int k = 0; k < NP; k++) ff_out[k] = ff_q[k] ^ hp_q[k];
`endif
  end

  // Mix: OW is wide enough that the sum of NCH 4-bit volumes cannot wrap.
  always_comb begin
    audout_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ff_out[i] | audc_q[i][4]) audout_d = audout_d + OW'(audc_q[i][3:0]);
    end
  end

  // Bus handshake and register state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q  <= 1'b0;
      dat_q  <= 8'h00;
      audf_q <= '{default: '0};
      audc_q <= '{default: '0};
      ctl_q  <= '0;
      link_q <= '0;
    end else begin
      ack_q  <= acc;
      if (acc) dat_q <= rdat;
      audf_q <= audf_d;
      audc_q <= audc_d;
      ctl_q  <= ctl_d;
      link_q <= link_d;
    end
  end

  // Audio datapath state: prescaler, counters, ffs, LFSRs, mix.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q    <= '0;
      m15_q    <= '0;
      cnt_q    <= '{default: '0};
      ff_q     <= '0;
      poly4_q  <= '0;
      poly5_q  <= '0;
      poly17_q <= '0;
      audout_q <= '0;
    end else begin
      pre_q    <= pre_d;
      m15_q    <= m15_d;
      cnt_q    <= cnt_d;
      ff_q     <= ff_d;
      poly4_q  <= poly4_d;
      poly5_q  <= poly5_d;
      poly17_q <= poly17_d;
      audout_q <= audout_d;
    end
  end

`ifdef POKEY_GEN_FILTER_EN
  // Filter enable and filter flops.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filt_q <= '0;
      hp_q   <= '0;
    end else begin
      filt_q <= filt_d;
      hp_q   <= hp_d;
    end
  end
`endif

  assign bus.ack_o  = ack_q;
  assign bus.dat_o  = dat_q;
  assign audout     = audout_q;
  assign chan_pulse = pulse;

endmodule

// File: tb/tb_pokey_audio_gen.sv
// Directed testbench for pokey_audio_gen with NCH=4.
module tb_pokey_audio_gen;
  localparam int unsigned NCH = 4;
  localparam int unsigned AW  = 4;
  localparam int unsigned OW  = 6;

  localparam logic [AW-1:0] ACtl    = 4'd8;
  localparam logic [AW-1:0] ALink   = 4'd9;
  localparam logic [AW-1:0] AFilt   = 4'd10;
  localparam logic [AW-1:0] AStimer = 4'd11;
  localparam logic [AW-1:0] ARandom = 4'd12;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [OW-1:0]  audout;
  logic [NCH-1:0] chan_pulse;
  int             tests = 0;
  int             fails = 0;

  pokey_audio_gen_if #(.AW(AW)) bus_if ();

  pokey_audio_gen #(
    .NCH       (NCH),
    .PRE_DIV   (28),
    .PRE_MUL15 (4)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .bus        (bus_if),
    .audout     (audout),
    .chan_pulse (chan_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle();
    int guard = 0;
    @(negedge clk);
    while (bus_if.ack_o === 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (guard >= 8) begin
      fails++;
      $display("FAIL bus_idle: ack_o=%b stuck, required 0", bus_if.ack_o);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] adr, input logic [7:0] dat);
    wait_idle();
    bus_if.adr_i = adr;
    bus_if.dat_i = dat;
    bus_if.we_i  = 1'b1;
    bus_if.stb_i = 1'b1;
    @(posedge clk); #1;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    tests++;
    if (bus_if.ack_o !== 1'b1) begin
      fails++;
      $display("FAIL write_ack adr=%0d: ack_o=%b, required 1", adr, bus_if.ack_o);
    end
  endtask

  task automatic bus_read(input logic [AW-1:0] adr, output logic [7:0] dat);
    wait_idle();
    bus_if.adr_i = adr;
    bus_if.we_i  = 1'b0;
    bus_if.stb_i = 1'b1;
    @(posedge clk); #1;
    bus_if.stb_i = 1'b0;
    dat = bus_if.dat_o;
    tests++;
    if (bus_if.ack_o !== 1'b1) begin
      fails++;
      $display("FAIL read_ack adr=%0d: ack_o=%b, required 1", adr, bus_if.ack_o);
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    logic       nz;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (audout !== '0 || bus_if.ack_o !== 1'b0 || bus_if.dat_o !== 8'h00 || chan_pulse !== '0) begin
      fails++;
      $display("FAIL reset_state: audout=%0d ack=%b dat=%h pulse=%b, required 0 0 00 0",
               audout, bus_if.ack_o, bus_if.dat_o, chan_pulse);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(ARandom, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL random_first: got %h, required 00", d);
    end
    nz = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(posedge clk);
      bus_read(ARandom, d);
      if (d !== 8'h00) nz = 1'b1;
    end
    tests++;
    if (nz !== 1'b1) begin
      fails++;
      $display("FAIL random_changes: all later reads 00, required some nonzero");
    end
  endtask

  task automatic test_fast_tone();
    logic          exp_p;
    logic [OW-1:0] exp_a;
    bus_write(ACtl, 8'h04);
    bus_write(4'd0, 8'd3);
    bus_write(4'd1, 8'hAF);
    bus_write(AStimer, 8'h00);
    for (int n = 0; n < 16; n++) begin
      exp_p = ((n % 4) == 3);
      tests++;
      if (chan_pulse[0] !== exp_p) begin
        fails++;
        $display("FAIL fast_pulse n=%0d: got %b, required %b", n, chan_pulse[0], exp_p);
      end
      if (n >= 1) begin
        exp_a = ((((n - 1) / 4) % 2) == 1) ? OW'(15) : OW'(0);
        tests++;
        if (audout !== exp_a) begin
          fails++;
          $display("FAIL fast_audout n=%0d: got %0d, required %0d", n, audout, exp_a);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_link();
    logic          exp_p;
    logic [OW-1:0] exp_a;
    bus_write(4'd1, 8'h00);
    bus_write(ALink, 8'h01);
    bus_write(4'd0, 8'd1);
    bus_write(4'd2, 8'd2);
    bus_write(4'd3, 8'hA5);
    bus_write(AStimer, 8'h00);
    for (int n = 0; n < 18; n++) begin
      exp_p = ((n % 6) == 5);
      tests++;
      if (chan_pulse[1] !== exp_p) begin
        fails++;
        $display("FAIL link_pulse n=%0d: got %b, required %b", n, chan_pulse[1], exp_p);
      end
      if (n >= 1) begin
        exp_a = ((((n - 1) / 6) % 2) == 1) ? OW'(5) : OW'(0);
        tests++;
        if (audout !== exp_a) begin
          fails++;
          $display("FAIL link_audout n=%0d: got %0d, required %0d", n, audout, exp_a);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_vol_only();
    bus_write(ALink, 8'h00);
    for (int i = 0; i < 4; i++) bus_write(AW'(2 * i + 1), 8'h1F);
    @(posedge clk); #1;
    tests++;
    if (audout !== OW'(60)) begin
      fails++;
      $display("FAIL vol_only_all: got %0d, required 60", audout);
    end
    bus_write(4'd5, 8'h13);
    @(posedge clk); #1;
    tests++;
    if (audout !== OW'(48)) begin
      fails++;
      $display("FAIL vol_only_mix: got %0d, required 48", audout);
    end
  endtask

  task automatic test_filter();
    logic [7:0] d;
    for (int i = 0; i < 4; i++) bus_write(AW'(2 * i + 1), 8'h00);
`ifdef POKEY_GEN_FILTER_EN
    bus_write(ACtl, 8'h04);
    bus_write(4'd0, 8'd2);
    bus_write(4'd4, 8'd2);
    bus_write(4'd1, 8'hA7);
    bus_write(4'd5, 8'hA0);
    bus_write(AFilt, 8'h01);
    bus_write(AStimer, 8'h00);
    for (int n = 0; n < 24; n++) begin
      if (n >= 1) begin
        tests++;
        if (audout !== '0) begin
          fails++;
          $display("FAIL filter_cancel n=%0d: got %0d, required 0", n, audout);
        end
      end
      @(posedge clk); #1;
    end
    bus_read(AFilt, d);
    tests++;
    if (d !== 8'h01) begin
      fails++;
      $display("FAIL filt_read: got %h, required 01", d);
    end
    bus_write(AFilt, 8'h00);
`else
    bus_write(AFilt, 8'h0F);
    bus_read(AFilt, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL filt_read: got %h, required 00", d);
    end
`endif
  endtask

  task automatic test_held_stb();
    logic       a1, a2, a3;
    logic [7:0] d;
    wait_idle();
    bus_if.adr_i = 4'd6;
    bus_if.dat_i = 8'h5A;
    bus_if.we_i  = 1'b1;
    bus_if.stb_i = 1'b1;
    @(posedge clk); #1;
    a1 = bus_if.ack_o;
    @(posedge clk); #1;
    a2 = bus_if.ack_o;
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    @(posedge clk); #1;
    a3 = bus_if.ack_o;
    tests++;
    if ({a1, a2, a3} !== 3'b100) begin
      fails++;
      $display("FAIL held_stb_ack: got %b%b%b, required 100", a1, a2, a3);
    end
    bus_read(4'd6, d);
    tests++;
    if (d !== 8'h5A) begin
      fails++;
      $display("FAIL held_stb_data: got %h, required 5a", d);
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] d;
    bus_read(4'd13, d);
    tests++;
    if (d !== 8'hFF) begin
      fails++;
      $display("FAIL unmapped13: got %h, required ff", d);
    end
    bus_write(4'd14, 8'h12);
    bus_read(4'd14, d);
    tests++;
    if (d !== 8'hFF) begin
      fails++;
      $display("FAIL unmapped14: got %h, required ff", d);
    end
    bus_write(ACtl, 8'hF8);
    bus_read(ACtl, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL ctl_mask: got %h, required 00", d);
    end
    bus_write(ACtl, 8'h07);
    bus_read(ACtl, d);
    tests++;
    if (d !== 8'h07) begin
      fails++;
      $display("FAIL ctl_read: got %h, required 07", d);
    end
    bus_read(AStimer, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL stimer_read: got %h, required 00", d);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [7:0] d;
    bus_write(ACtl, 8'h04);
    bus_write(4'd0, 8'd0);
    bus_write(4'd1, 8'h1F);
    repeat (6) @(posedge clk);
    #1;
    tests++;
    if (audout !== OW'(15) || chan_pulse[0] !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_run: audout=%0d pulse0=%b, required 15 1", audout, chan_pulse[0]);
    end
    @(negedge clk);
    bus_if.adr_i = 4'd2;
    bus_if.dat_i = 8'h77;
    bus_if.we_i  = 1'b1;
    bus_if.stb_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (audout !== '0 || chan_pulse !== '0 || bus_if.ack_o !== 1'b0 || bus_if.dat_o !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: audout=%0d pulse=%b ack=%b dat=%h, required 0 0 0 00",
               audout, chan_pulse, bus_if.ack_o, bus_if.dat_o);
    end
    bus_if.stb_i = 1'b0;
    bus_if.we_i  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(4'd2, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL dropped_write: got %h, required 00", d);
    end
    bus_read(4'd1, d);
    tests++;
    if (d !== 8'h00) begin
      fails++;
      $display("FAIL audc_cleared: got %h, required 00", d);
    end
  endtask

  initial begin
    bus_if.adr_i = '0;
    bus_if.dat_i = 8'h00;
    bus_if.we_i  = 1'b0;
    bus_if.stb_i = 1'b0;
    test_reset();
    test_fast_tone();
    test_link();
    test_vol_only();
    test_filter();
    test_held_stb();
    test_unmapped();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
